// File: rtl/wb_result_arbiter.sv
// Writeback result arbiter: buffers single-cycle FU results in per-FU FIFOs and
// round-robins them onto one registered result bus toward the ROB.
`ifndef ROB_QUEUE_BITS
`define ROB_QUEUE_BITS 6
`endif

module wb_result_arbiter #(
  parameter int NUM_FU     = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int UID_W      = `ROB_QUEUE_BITS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_FU-1:0]       in_valid,
  input  logic [NUM_FU*UID_W-1:0] in_uid,
  input  logic [NUM_FU*16-1:0]    in_val,
  input  logic [NUM_FU*18-1:0]    in_loc,
  output logic [NUM_FU-1:0]       fu_stall,
  input  logic                    rob_ready,
  output logic                    cdb_valid,
  output logic [UID_W-1:0]        cdb_uid,
  output logic [15:0]             cdb_val,
  output logic [17:0]             cdb_loc,
  output logic                    cdb_is_reg,
  output logic                    overflow_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int FW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam int EW = UID_W + 16 + 18;

  typedef logic [EW-1:0] entry_t;

  entry_t            mem    [NUM_FU][FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr [NUM_FU];
  logic [PW-1:0]     rd_ptr [NUM_FU];
  logic [PW-1:0]     cnt_next [NUM_FU];
  logic [FW-1:0]     rr_ptr;
  logic [NUM_FU-1:0] empty;
  logic [NUM_FU-1:0] full;
  logic [NUM_FU-1:0] pop;
  logic [NUM_FU-1:0] push;
  logic [NUM_FU-1:0] stall_next;
  logic              load;
  logic              found;
  logic              drop_any;
  logic [FW-1:0]     grant;
  logic [FW-1:0]     scan_idx;
  logic [FW:0]       scan_sum;
  entry_t            head;

  always_comb begin
    empty = '0;
    full  = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      empty[i] = (wr_ptr[i] == rd_ptr[i]);
      full[i]  = (wr_ptr[i][AW-1:0] == rd_ptr[i][AW-1:0]) &&
                 (wr_ptr[i][AW] != rd_ptr[i][AW]);
    end
  end

  // Scan from rr_ptr upward, wrapping, using only start-of-cycle FIFO state.
  always_comb begin
    found    = 1'b0;
    grant    = '0;
    scan_sum = '0;
    scan_idx = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      scan_sum = {1'b0, rr_ptr} + (FW+1)'(k);
      if (scan_sum >= (FW+1)'(NUM_FU))
        scan_sum = scan_sum - (FW+1)'(NUM_FU);
      scan_idx = scan_sum[FW-1:0];
      if (!found && !empty[scan_idx]) begin
        found = 1'b1;
        grant = scan_idx;
      end
    end
  end

  assign load = !cdb_valid || rob_ready;
  assign head = mem[grant][rd_ptr[grant][AW-1:0]];

  // A full FIFO still accepts a push when it is being popped in the same cycle.
  always_comb begin
    pop        = '0;
    push       = '0;
    stall_next = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      pop[i]  = load && found && (grant == FW'(i));
      push[i] = in_valid[i] && (!full[i] || pop[i]);
      cnt_next[i] = (wr_ptr[i] - rd_ptr[i]) + PW'(push[i]) - PW'(pop[i]);
      stall_next[i] = (cnt_next[i] >= PW'(FIFO_DEPTH - 1));
    end
  end

  assign drop_any = |(in_valid & full & ~pop);

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (push[i])
        mem[i][wr_ptr[i][AW-1:0]] <= {in_uid[i*UID_W +: UID_W],
                                      in_val[i*16 +: 16],
                                      in_loc[i*18 +: 18]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_FU; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
      rr_ptr       <= '0;
      fu_stall     <= '0;
      cdb_valid    <= 1'b0;
      cdb_uid      <= '0;
      cdb_val      <= '0;
      cdb_loc      <= '0;
      cdb_is_reg   <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (push[i])
          wr_ptr[i] <= wr_ptr[i] + PW'(1);
        if (pop[i])
          rd_ptr[i] <= rd_ptr[i] + PW'(1);
      end
      fu_stall <= stall_next;
      if (drop_any)
        overflow_err <= 1'b1;
      if (load) begin
        if (found) begin
          cdb_valid  <= 1'b1;
          {cdb_uid, cdb_val, cdb_loc} <= head;
          cdb_is_reg <= (head[17:16] == 2'b00);
          rr_ptr     <= (grant == FW'(NUM_FU - 1)) ? '0 : grant + FW'(1);
        end else begin
          cdb_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_result_arbiter.sv
// Directed self-checking bench for wb_result_arbiter (NUM_FU=4, FIFO_DEPTH=4, UID_W=6).
module tb_wb_result_arbiter;

  localparam int NFU = 4;
  localparam int UW  = 6;

  logic            clk = 1'b0;
  logic            rst;
  logic [NFU-1:0]  in_valid;
  logic [NFU*UW-1:0] in_uid;
  logic [NFU*16-1:0] in_val;
  logic [NFU*18-1:0] in_loc;
  logic [NFU-1:0]  fu_stall;
  logic            rob_ready;
  logic            cdb_valid;
  logic [UW-1:0]   cdb_uid;
  logic [15:0]     cdb_val;
  logic [17:0]     cdb_loc;
  logic            cdb_is_reg;
  logic            overflow_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_result_arbiter #(.NUM_FU(NFU), .FIFO_DEPTH(4), .UID_W(UW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_uid(in_uid), .in_val(in_val), .in_loc(in_loc),
    .fu_stall(fu_stall), .rob_ready(rob_ready),
    .cdb_valid(cdb_valid), .cdb_uid(cdb_uid), .cdb_val(cdb_val),
    .cdb_loc(cdb_loc), .cdb_is_reg(cdb_is_reg), .overflow_err(overflow_err)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int fu, input logic [UW-1:0] uid,
                               input logic [15:0] val, input logic [17:0] loc);
    in_valid[fu]          = 1'b1;
    in_uid[fu*UW +: UW]   = uid;
    in_val[fu*16 +: 16]   = val;
    in_loc[fu*18 +: 18]   = loc;
  endtask

  task automatic clearStimulus();
    in_valid = '0;
  endtask

  task automatic resetDut();
    clearStimulus();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = '0; in_uid = '0; in_val = '0; in_loc = '0; rob_ready = 1'b1;
    #1;
    checkOutput("rst_cdb_valid", 32'(cdb_valid), 0);
    checkOutput("rst_fu_stall", 32'(fu_stall), 0);
    checkOutput("rst_overflow", 32'(overflow_err), 0);
    checkOutput("rst_cdb_uid", 32'(cdb_uid), 0);
    tick();
    rst = 1'b0;

    // single result, two-cycle latency
    applyStimulus(0, 6'd5, 16'hFF80, 18'h00003);
    tick();
    clearStimulus();
    checkOutput("single_not_early", 32'(cdb_valid), 0);
    tick();
    checkOutput("single_valid", 32'(cdb_valid), 1);
    checkOutput("single_uid", 32'(cdb_uid), 5);
    checkOutput("single_val", 32'(cdb_val), 32'hFF80);
    checkOutput("single_loc", 32'(cdb_loc), 3);
    checkOutput("single_is_reg", 32'(cdb_is_reg), 1);
    tick();
    checkOutput("single_drain", 32'(cdb_valid), 0);

    // round robin over all four FUs
    resetDut();
    for (int k = 0; k < NFU; k++)
      applyStimulus(k, UW'(k + 1), 16'(16'h100 + k), 18'(k));
    tick();
    clearStimulus();
    for (int k = 0; k < NFU; k++) begin
      tick();
      checkOutput($sformatf("rr_valid%0d", k), 32'(cdb_valid), 1);
      checkOutput($sformatf("rr_uid%0d", k), 32'(cdb_uid), 32'(k + 1));
    end
    tick();
    checkOutput("rr_drain", 32'(cdb_valid), 0);
    applyStimulus(1, 6'd11, 16'h0011, 18'h00001);
    applyStimulus(0, 6'd10, 16'h0010, 18'h00000);
    tick();
    clearStimulus();
    tick();
    checkOutput("rr_wrap_first", 32'(cdb_uid), 10);
    tick();
    checkOutput("rr_wrap_second", 32'(cdb_uid), 11);

    // backpressure hold
    resetDut();
    applyStimulus(0, 6'd7, 16'h0707, 18'h00007);
    applyStimulus(1, 6'd8, 16'h0808, 18'h10005);
    tick();
    clearStimulus();
    rob_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      checkOutput($sformatf("bp_valid%0d", c), 32'(cdb_valid), 1);
      checkOutput($sformatf("bp_uid%0d", c), 32'(cdb_uid), 7);
      checkOutput($sformatf("bp_val%0d", c), 32'(cdb_val), 32'h0707);
    end
    rob_ready = 1'b1;
    tick();
    checkOutput("bp_next_uid", 32'(cdb_uid), 8);
    checkOutput("bp_next_loc", 32'(cdb_loc), 32'h10005);
    checkOutput("bp_next_not_reg", 32'(cdb_is_reg), 0);
    tick();
    checkOutput("bp_drain", 32'(cdb_valid), 0);

    // stall and overflow with the bus held
    resetDut();
    rob_ready = 1'b0;
    applyStimulus(1, 6'd9, 16'h0009, 18'h00009);
    tick();
    clearStimulus();
    tick();
    checkOutput("full_hold_uid", 32'(cdb_uid), 9);
    for (int p = 0; p < 5; p++) begin
      applyStimulus(0, UW'(20 + p), 16'(16'h2000 + p), 18'(p));
      tick();
      if (p == 1) checkOutput("stall_after2", 32'(fu_stall), 0);
      if (p == 2) checkOutput("stall_after3", 32'(fu_stall), 1);
      if (p == 3) begin
        checkOutput("fourth_accepted", 32'(overflow_err), 0);
        checkOutput("stall_after4", 32'(fu_stall), 1);
      end
    end
    clearStimulus();
    checkOutput("fifth_dropped", 32'(overflow_err), 1);
    rob_ready = 1'b1;
    for (int p = 0; p < 4; p++) begin
      tick();
      checkOutput($sformatf("full_drain_uid%0d", p), 32'(cdb_uid), 32'(20 + p));
      if (p == 0) checkOutput("stall_hold", 32'(fu_stall), 1);
      if (p == 1) checkOutput("stall_release", 32'(fu_stall), 0);
    end
    tick();
    checkOutput("full_drain_end", 32'(cdb_valid), 0);
    checkOutput("overflow_sticky", 32'(overflow_err), 1);

    // pointer wrap: ten results streamed through FU2
    resetDut();
    rob_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      clearStimulus();
      if (c < 10) applyStimulus(2, UW'(30 + c), 16'(16'h1000 + c), 18'(18'h00200 + c));
      tick();
      if (c >= 1 && c <= 10) begin
        checkOutput($sformatf("wrap_valid%0d", c - 1), 32'(cdb_valid), 1);
        checkOutput($sformatf("wrap_uid%0d", c - 1), 32'(cdb_uid), 32'(30 + c - 1));
        checkOutput($sformatf("wrap_val%0d", c - 1), 32'(cdb_val), 32'(16'h1000 + c - 1));
      end
    end
    checkOutput("wrap_end", 32'(cdb_valid), 0);
    checkOutput("wrap_no_overflow", 32'(overflow_err), 0);

    // asynchronous reset mid-cycle
    resetDut();
    rob_ready = 1'b0;
    for (int p = 0; p < 4; p++) begin
      applyStimulus(0, UW'(50 + p), 16'(p), 18'(p));
      tick();
    end
    clearStimulus();
    checkOutput("pre_rst_valid", 32'(cdb_valid), 1);
    checkOutput("pre_rst_stall", 32'(fu_stall), 1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_valid", 32'(cdb_valid), 0);
    checkOutput("async_rst_stall", 32'(fu_stall), 0);
    tick();
    rst = 1'b0;
    rob_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      checkOutput($sformatf("post_rst_idle%0d", c), 32'(cdb_valid), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_result_arbiter.md
Name: wb_result_arbiter

Overview:
- Writeback stage directly downstream of the single-cycle functional units (movl and its siblings).
- Each FU presents {has_outgoing, out_uid, result_val, out_loc} with no stall input. This block buffers those results in per-FU FIFOs.
- It round-robin arbitrates them onto a single registered result bus toward the ROB, one result per cycle.
- It returns per-FU stall flags to issue logic so FUs are never sent work that cannot be buffered.

Parameters:
- NUM_FU, 4, number of functional-unit result ports.
- FIFO_DEPTH, 4, entries per FU FIFO; power of two, >= 2.
- UID_W, `ROB_QUEUE_BITS, ROB tag width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  NUM_FU  per-FU has_outgoing.
- in_uid  in  NUM_FU*UID_W  per-FU out_uid; FU i occupies slice [i*UID_W +: UID_W].
- in_val  in  NUM_FU*16  per-FU result_val.
- in_loc  in  NUM_FU*18  per-FU out_loc; loc[17:16]==2'b00 means register target.
- fu_stall  out  NUM_FU  registered; issue must not dispatch to FU i while high.
- rob_ready  in  1  ROB accepts cdb_* this cycle.
- cdb_valid  out  1  registered result valid.
- cdb_uid  out  UID_W  result tag.
- cdb_val  out  16  result value.
- cdb_loc  out  18  destination location, passed through unmodified.
- cdb_is_reg  out  1  registered; equals (cdb_loc[17:16]==2'b00).
- overflow_err  out  1  sticky error flag; set on a dropped push.

Behaviour:
- Reset (async assert, sync-released use):
  - all outputs 0; fu_stall=0; cdb_valid=0; overflow_err=0.
  - all FIFO read/write pointers 0; rr_ptr=0.
- FIFO storage:
  - Per FU: a circular buffer of {uid, val, loc}.
  - Pointers are log2(FIFO_DEPTH)+1 bits with an extra wrap bit.
  - Full when low bits are equal and wrap bits differ; empty when the pointers are equal.
- Push: on an edge where in_valid[i]=1, write entry i.
  - Exception: FIFO i is full and is not popped that same cycle. The entry is dropped and overflow_err is set until rst.
- Simultaneous push and pop on the same FIFO is always legal, including when the FIFO is full; count is unchanged.
- Load condition: load = !cdb_valid || rob_ready.
- When load=1:
  - Scan FIFOs starting at index rr_ptr, ascending and wrapping modulo NUM_FU.
  - The first non-empty FIFO g wins. Pop its head into the cdb_* registers, set cdb_valid=1, and set rr_ptr=(g+1) mod NUM_FU.
  - If all FIFOs are empty: cdb_valid<=0 and rr_ptr is unchanged.
- When load=0 (cdb_valid && !rob_ready):
  - Hold all cdb_* outputs stable; no pop occurs.
  - Pushes continue.
- Arbitration uses only FIFO state at the start of the cycle. There is no same-cycle bypass from in_* to cdb_*.
  - Minimum latency: in_valid at cycle t gives cdb_valid at cycle t+2 (write at edge t, pop/load at edge t+1).
- Ordering: results from the same FU leave in arrival order. No ordering is guaranteed across FUs.
- fu_stall[i]:
  - Registered value of (next-cycle count_i >= FIFO_DEPTH-1).
  - This leaves one slot of slack for the push that issue may already have in flight.
  - Deasserts the cycle after a pop brings next-cycle count_i below FIFO_DEPTH-1.
- Fairness: a continuously non-empty FIFO is granted at least once every NUM_FU loads.
- Reset mid-operation: all buffered results are discarded immediately; cdb_valid falls asynchronously.

Test Plan:
- Single result, NUM_FU=4: in_valid=4'b0001, uid=5, val=16'hFF80, loc=18'h00003 at cycle 0 -> cdb_valid=1 at cycle 2 with uid=5, val=FF80, loc=00003, cdb_is_reg=1. Cycle 3: cdb_valid=0.
- Round-robin: all four FUs push uid 1,2,3,4 in one cycle, rob_ready=1 -> cdb_uid sequence 1,2,3,4 on consecutive cycles. rr_ptr then returns to 0.
- Backpressure: rob_ready=0 for 3 cycles with uid=7 on the bus -> cdb_* held at uid 7 throughout. Next uid appears the cycle after rob_ready=1.
- Stall and full, FIFO_DEPTH=4, rob_ready=0:
  - Push FU0 three times -> fu_stall[0]=1 the cycle after the 3rd push.
  - A 4th push is accepted.
  - A 5th push is dropped -> overflow_err=1 and stays 1.
- Pointer wrap: stream 10 results through FU2 with rob_ready=1 -> all 10 emerge in order, uids intact, no overflow.
- Async reset with FIFOs holding entries and cdb_valid=1: pulse rst mid-cycle -> cdb_valid=0 and fu_stall=0 immediately. After release, no stale result is emitted.
